player_hit_unit: RTL and testbench
==================================

# player_hit_unit

Player-side receiver for enemy projectiles. It watches the position of every enemy projectile and the player each `clk_4` tick. When a projectile overlaps the player's hit box, it asserts the per-source `destroy` handshake back to the firing enemy and removes one life. It then holds a post-hit invulnerability window and flags game over when lives reach zero. It sits between the enemy blocks, which own projectile motion, and the top-level game/VGA logic, which consumes lives, blink and game-over status.

## Interface
- `NUM_SRC`, 3: number of enemy projectile sources.
- `LIVES`, 3: lives loaded at start of play (1..7).
- `HIT_W`, 10: horizontal hit half-width, in pixels.
- `HIT_H`, 10: vertical hit half-height, in pixels.
- `INVULN_TICKS`, 120: length of the invulnerability window, in `clk_4` cycles.
- `clk_4`  in  1  game-logic clock; all state changes on its rising edge.
- `clr`  in  1  reset; asynchronous, active-high.
- `play`  in  1  game running; low = idle/restart.
- `player_x`  in  10  player centre x.
- `player_y`  in  10  player centre y.
- `proj_x`  in  10*NUM_SRC  packed enemy projectile x; source i occupies [10i+9:10i].
- `proj_y`  in  10*NUM_SRC  packed enemy projectile y; 0 = inactive.
- `destroy`  out  NUM_SRC  per-source kill request to the enemy block.
- `hit`  out  1  one-cycle pulse on each life loss.
- `lives`  out  3  remaining lives.
- `invuln`  out  1  invulnerability window active.
- `flash`  out  1  player blink enable for display.
- `game_over`  out  1  lives exhausted.

## Operation
- States: IDLE, ALIVE, INVULN, DEAD.
- Projectile protocol:
  - Source i is active when `proj_y[i] > 0`.
  - The enemy clears its projectile to y=0 while `destroy[i]` is high.
- Overlap for source i: active, `|proj_x - player_x| < HIT_W` and `|proj_y - player_y| < HIT_H`.
  - Differences are computed as 11-bit unsigned magnitudes (larger minus smaller), so no wrap.
- `destroy[i]` handshake:
  - Set on a registered overlap.
  - Held until `proj_y[i] == 0` is sampled; cleared on the following edge.
  - Never re-set for the same source while still high.
- State transitions:
  - IDLE: `lives=LIVES`; all outputs otherwise 0. Go to ALIVE on the first edge with `play=1`.
  - ALIVE: any overlap sets destroy on every overlapping source, pulses `hit`, and decrements `lives` by exactly 1. This holds even when several sources overlap in the same cycle.
    - If the new `lives` is 0, go to DEAD.
    - Otherwise load the invulnerability counter with `INVULN_TICKS-1` and go to INVULN.
  - INVULN: overlapping projectiles are still destroyed (absorbed), but there is no `hit` and no life loss. The counter decrements each cycle; at 0 go to ALIVE.
  - DEAD: `game_over=1`. No further hits. Pending `destroy` bits still complete their handshake.
- `play=0` in any state: next edge goes to IDLE; `destroy` cleared; `lives` reloaded; counter cleared.
- `clr`: immediately forces IDLE.
  - Reset values: `destroy=0`, `hit=0`, `lives=LIVES`, `invuln=0`, `flash=0`, `game_over=0`, counter 0.

## Timing
- Inputs sampled at edge N; `destroy`, `hit`, `lives` and the state update at edge N+1. Latency is 1 cycle.
- `hit` is high for exactly one cycle per life lost.
- `invuln` is high for exactly `INVULN_TICKS` cycles, starting the cycle `hit` is high.
- `destroy[i]` minimum width is 1 cycle. It falls 1 cycle after `proj_y[i]==0` is seen.
- An overlap in the final INVULN cycle is absorbed. An overlap on the first ALIVE cycle costs a life.

## Configuration
- `INVULN_FLASH_EN` defined: `flash` = bit 3 of the invulnerability counter while INVULN, else 0. The player blinks with an 8-cycle half-period.
- `INVULN_FLASH_EN` undefined: `flash` is tied to 0 and the counter bit is unused.

## Structure
- Shared package `defender_pkg`: `COORD_W=10`, `SCREEN_H=480`, player state enum (IDLE/ALIVE/INVULN/DEAD).
- Sub-module `hit_box_cmp`:
  - Combinational, one per source via generate.
  - Inputs: projectile x/y, player x/y, `HIT_W`, `HIT_H`.
  - Output: `overlap`.

## Test plan
- Single hit: player (320,440), src0 at (325,435), `play=1`.
  - Next cycle `destroy[0]=1`, `hit=1`, `lives` 3->2, `invuln=1`.
  - Drive `proj_y[0]=0`; `destroy[0]` drops one cycle later.
- Near miss: src0 at (330,440) with `HIT_W=10` gives no hit. (329,440) gives a hit.
- Simultaneous: src0 and src1 overlap in the same cycle.
  - `destroy=3'b011`, one `hit` pulse, `lives` 3->2.
- Invulnerability: overlap at cycle 50 of INVULN gives `destroy` set, no `hit`, `lives` unchanged.
  - `invuln` drops after 120 cycles total.
  - With `INVULN_FLASH_EN`, `flash` toggles every 8 cycles.
- Game over: three hits spaced more than 120 cycles apart give `lives=0` and `game_over=1`. A fourth overlap still gets `destroy` but gives no `hit`.
- Reset/restart:
  - `clr` mid-INVULN: all outputs return to reset values asynchronously.
  - `play=0` in DEAD: IDLE, `lives=3`, `game_over=0` on the next edge.

Source files
------------

// File: rtl/defender_pkg.sv
// Shared definitions for the defender game-logic blocks: coordinate width,
// screen geometry, player state encoding and a coordinate distance helper.
package defender_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE,
        ALIVE,
        INVULN,
        DEAD
    } player_state_t;

    // Magnitude of the difference, one bit wider than a coordinate so it never wraps.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] ea;
        logic [COORD_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea > eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// Combinational overlap test between one enemy projectile and the player hit box.
// A projectile at y = 0 is inactive and never overlaps.
module hit_box_cmp
    import defender_pkg::*;
#(
    parameter int HIT_W = 10,
    parameter int HIT_H = 10
) (
    input  logic [COORD_W-1:0] proj_x,
    input  logic [COORD_W-1:0] proj_y,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    output logic               overlap
);

    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic             active;

    always_comb begin
        dx      = abs_diff(proj_x, player_x);
        dy      = abs_diff(proj_y, player_y);
        active  = (proj_y != '0);
        overlap = active && (dx < (COORD_W+1)'(HIT_W)) && (dy < (COORD_W+1)'(HIT_H));
    end

endmodule

// File: rtl/player_hit_unit.sv
// Player-side projectile receiver: destroy handshake, life counting, invulnerability
// window and game over. Define INVULN_FLASH_EN to drive flash from the window counter.
module player_hit_unit
    import defender_pkg::*;
#(
    parameter int NUM_SRC      = 3,
    parameter int LIVES        = 3,
    parameter int HIT_W        = 10,
    parameter int HIT_H        = 10,
    parameter int INVULN_TICKS = 120
) (
    input  logic                       clk_4,
    input  logic                       clr,
    input  logic                       play,
    input  logic [COORD_W-1:0]         player_x,
    input  logic [COORD_W-1:0]         player_y,
    input  logic [COORD_W*NUM_SRC-1:0] proj_x,
    input  logic [COORD_W*NUM_SRC-1:0] proj_y,
    output logic [NUM_SRC-1:0]         destroy,
    output logic                       hit,
    output logic [2:0]                 lives,
    output logic                       invuln,
    output logic                       flash,
    output logic                       game_over
);

    // At least 4 bits so the blink tap always exists.
    localparam int CNT_W = (INVULN_TICKS > 16) ? $clog2(INVULN_TICKS) : 4;

    player_state_t      state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_SRC-1:0] overlap;
    logic [NUM_SRC-1:0] src_active;
    logic [NUM_SRC-1:0] new_hit;
    logic [NUM_SRC-1:0] destroy_next;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
        hit_box_cmp #(
            .HIT_W(HIT_W),
            .HIT_H(HIT_H)
        ) u_cmp (
            .proj_x  (proj_x[COORD_W*i +: COORD_W]),
            .proj_y  (proj_y[COORD_W*i +: COORD_W]),
            .player_x(player_x),
            .player_y(player_y),
            .overlap (overlap[i])
        );
    end

    // A source already being destroyed is neither re-set nor counted as a fresh hit.
    always_comb begin
        src_active = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_active[i] = (proj_y[COORD_W*i +: COORD_W] != '0);
        end
        new_hit      = overlap & ~destroy;
        destroy_next = (destroy & src_active) | new_hit;
    end

    always_ff @(posedge clk_4 or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            destroy   <= '0;
            hit       <= 1'b0;
            lives     <= 3'(LIVES);
            invuln    <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
        end else if (!play) begin
            state     <= IDLE;
            destroy   <= '0;
            hit       <= 1'b0;
            lives     <= 3'(LIVES);
            invuln    <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
        end else begin
            hit <= 1'b0;
            if (state != IDLE) begin
                destroy <= destroy_next;
            end
            case (state)
                IDLE: begin
                    state <= ALIVE;
                end
                ALIVE: begin
                    if (|new_hit) begin
                        hit   <= 1'b1;
                        lives <= lives - 3'd1;
                        if (lives == 3'd1) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                        end else begin
                            state  <= INVULN;
                            invuln <= 1'b1;
                            cnt    <= CNT_W'(INVULN_TICKS - 1);
                        end
                    end
                end
                INVULN: begin
                    if (cnt == '0) begin
                        state  <= ALIVE;
                        invuln <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DEAD: begin
                    game_over <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INVULN_FLASH_EN
    assign flash = (state == INVULN) && cnt[3];
`else
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_player_hit_unit.sv
// Directed self-checking bench for player_hit_unit (NUM_SRC=3, LIVES=3, 10x10 box, 120-tick window).
module tb_player_hit_unit;

    logic        clk_4 = 1'b0;
    logic        clr;
    logic        play;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [29:0] proj_x;
    logic [29:0] proj_y;
    logic [2:0]  destroy;
    logic        hit;
    logic [2:0]  lives;
    logic        invuln;
    logic        flash;
    logic        game_over;

    int vectors    = 0;
    int miscompares = 0;

    player_hit_unit #(
        .NUM_SRC     (3),
        .LIVES       (3),
        .HIT_W       (10),
        .HIT_H       (10),
        .INVULN_TICKS(120)
    ) dut (
        .clk_4    (clk_4),
        .clr      (clr),
        .play     (play),
        .player_x (player_x),
        .player_y (player_y),
        .proj_x   (proj_x),
        .proj_y   (proj_y),
        .destroy  (destroy),
        .hit      (hit),
        .lives    (lives),
        .invuln   (invuln),
        .flash    (flash),
        .game_over(game_over)
    );

    always #5 clk_4 = ~clk_4;

    task automatic tick();
        @(posedge clk_4);
        #1;
    endtask

    task automatic set_proj(input int i, input int x, input int y);
        proj_x[i*10 +: 10] = 10'(x);
        proj_y[i*10 +: 10] = 10'(y);
    endtask

    task automatic restart();
        play   = 1'b0;
        proj_x = '0;
        proj_y = '0;
        player_x = 10'd320;
        player_y = 10'd440;
        tick();
        play = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        play = 1'b0;
        player_x = 10'd320;
        player_y = 10'd440;
        proj_x = '0;
        proj_y = '0;
        #3;
        vectors++;
        if ({destroy, hit, lives, invuln, flash, game_over} !== {3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got destroy=%b hit=%b lives=%0d invuln=%b flash=%b go=%b, want 000 0 3 0 0 0",
                     destroy, hit, lives, invuln, flash, game_over);
        end
        tick();
        clr = 1'b0;
    endtask

    task automatic test_single_hit();
        restart();
        vectors++;
        if (hit !== 1'b0 || lives !== 3'd3) begin
            miscompares++;
            $display("FAIL alive_entry: hit=%b lives=%0d, want 0 3", hit, lives);
        end
        set_proj(0, 325, 435);
        tick();
        vectors++;
        if ({destroy, hit, lives, invuln} !== {3'b001, 1'b1, 3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL single_hit: destroy=%b hit=%b lives=%0d invuln=%b, want 001 1 2 1",
                     destroy, hit, lives, invuln);
        end
        tick();
        vectors++;
        if (destroy !== 3'b001 || hit !== 1'b0) begin
            miscompares++;
            $display("FAIL destroy_hold: destroy=%b hit=%b, want 001 0", destroy, hit);
        end
        set_proj(0, 325, 0);
        tick();
        vectors++;
        if (destroy !== 3'b000) begin
            miscompares++;
            $display("FAIL destroy_release: destroy=%b, want 000", destroy);
        end
    endtask

    task automatic test_near_miss();
        restart();
        set_proj(0, 330, 440);
        tick();
        vectors++;
        if (hit !== 1'b0 || destroy !== 3'b000 || lives !== 3'd3) begin
            miscompares++;
            $display("FAIL near_miss_x330: hit=%b destroy=%b lives=%0d, want 0 000 3", hit, destroy, lives);
        end
        set_proj(0, 329, 440);
        tick();
        vectors++;
        if (hit !== 1'b1 || destroy !== 3'b001 || lives !== 3'd2) begin
            miscompares++;
            $display("FAIL edge_hit_x329: hit=%b destroy=%b lives=%0d, want 1 001 2", hit, destroy, lives);
        end
        // y = 0 is inactive even when it lies inside the box
        restart();
        player_y = 10'd5;
        set_proj(1, 320, 0);
        tick();
        vectors++;
        if (hit !== 1'b0 || destroy !== 3'b000) begin
            miscompares++;
            $display("FAIL inactive_src: hit=%b destroy=%b, want 0 000", hit, destroy);
        end
        set_proj(1, 320, 14);
        tick();
        vectors++;
        if (hit !== 1'b1 || destroy !== 3'b010) begin
            miscompares++;
            $display("FAIL edge_hit_y14: hit=%b destroy=%b, want 1 010", hit, destroy);
        end
    endtask

    task automatic test_simultaneous();
        restart();
        set_proj(0, 325, 435);
        set_proj(1, 318, 445);
        tick();
        vectors++;
        if ({destroy, hit, lives} !== {3'b011, 1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL simultaneous: destroy=%b hit=%b lives=%0d, want 011 1 2", destroy, hit, lives);
        end
        tick();
        vectors++;
        if (hit !== 1'b0 || lives !== 3'd2) begin
            miscompares++;
            $display("FAIL single_pulse: hit=%b lives=%0d, want 0 2", hit, lives);
        end
    endtask

    task automatic test_invuln();
        int n;
        logic [6:0] cnt_exp;
        logic       flash_exp;
        restart();
        set_proj(0, 325, 435);
        tick();
        n = 0;
        while (invuln === 1'b1 && n < 300) begin
            n++;
            cnt_exp = 7'(120 - n);
`ifdef INVULN_FLASH_EN
            flash_exp = cnt_exp[3];
`else
            flash_exp = 1'b0;
`endif
            vectors++;
            if (flash !== flash_exp) begin
                miscompares++;
                $display("FAIL flash_n%0d: flash=%b, want %b", n, flash, flash_exp);
            end
            if (n == 1) set_proj(0, 325, 0);
            if (n == 50) set_proj(1, 325, 435);
            if (n == 51) begin
                vectors++;
                if ({destroy, hit, lives} !== {3'b010, 1'b0, 3'd2}) begin
                    miscompares++;
                    $display("FAIL absorb_mid: destroy=%b hit=%b lives=%0d, want 010 0 2", destroy, hit, lives);
                end
                set_proj(1, 325, 0);
            end
            if (n == 120) set_proj(2, 322, 442);
            tick();
        end
        vectors++;
        if (n !== 120) begin
            miscompares++;
            $display("FAIL invuln_len: got %0d cycles, want 120", n);
        end
        vectors++;
        if ({destroy, hit, lives, invuln} !== {3'b100, 1'b0, 3'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL absorb_last: destroy=%b hit=%b lives=%0d invuln=%b, want 100 0 2 0",
                     destroy, hit, lives, invuln);
        end
        set_proj(2, 322, 0);
        set_proj(0, 325, 435);
        tick();
        vectors++;
        if ({destroy, hit, lives, invuln} !== {3'b001, 1'b1, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL first_alive_hit: destroy=%b hit=%b lives=%0d invuln=%b, want 001 1 1 1",
                     destroy, hit, lives, invuln);
        end
    endtask

    task automatic test_game_over();
        int guard;
        restart();
        for (int k = 1; k <= 3; k++) begin
            set_proj(0, 325, 435);
            tick();
            vectors++;
            if (hit !== 1'b1 || lives !== 3'(3 - k) || game_over !== (k == 3)) begin
                miscompares++;
                $display("FAIL go_hit%0d: hit=%b lives=%0d go=%b, want 1 %0d %b",
                         k, hit, lives, game_over, 3 - k, (k == 3));
            end
            set_proj(0, 325, 0);
            guard = 0;
            while (invuln === 1'b1 && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) begin
                vectors++;
                miscompares++;
                $display("FAIL go_wait%0d: invuln still %b after %0d cycles, want 0", k, invuln, guard);
            end
            tick();
        end
        set_proj(1, 315, 445);
        tick();
        vectors++;
        if ({destroy, hit, lives, game_over, invuln} !== {3'b010, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dead_absorb: destroy=%b hit=%b lives=%0d go=%b invuln=%b, want 010 0 0 1 0",
                     destroy, hit, lives, game_over, invuln);
        end
        play = 1'b0;
        tick();
        vectors++;
        if ({destroy, lives, game_over} !== {3'b000, 3'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL dead_restart: destroy=%b lives=%0d go=%b, want 000 3 0", destroy, lives, game_over);
        end
    endtask

    task automatic test_clr_mid_invuln();
        restart();
        set_proj(0, 325, 435);
        tick();
        tick();
        tick();
        #2;
        clr = 1'b1;
        #1;
        vectors++;
        if ({destroy, hit, lives, invuln, flash, game_over} !== {3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_clr: destroy=%b hit=%b lives=%0d invuln=%b flash=%b go=%b, want 000 0 3 0 0 0",
                     destroy, hit, lives, invuln, flash, game_over);
        end
        set_proj(0, 325, 0);
        tick();
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_near_miss();
        test_simultaneous();
        test_invuln();
        test_game_over();
        test_clr_mid_invuln();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
